// File: rtl/wd_sup_pkg.sv
// Shared types and defaults for the watchdog supervisor.
// State encodings are visible on the state port, so they are fixed here.
package wd_sup_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_KICK     = 3'd2,
        ST_RECOVER  = 3'd3,
        ST_HOLDOFF  = 3'd4
    } wd_sup_state_t;

    localparam int DEFAULT_N_SRC          = 4;
    localparam int DEFAULT_MIN_KICK_GAP   = 16;
    localparam int DEFAULT_RECOVER_CYCLES = 64;
    localparam int TRIP_COUNT_W           = 8;

    function automatic logic is_supervising(input wd_sup_state_t s);
        return (s == ST_ARMED) || (s == ST_KICK);
    endfunction

endpackage

// File: rtl/wd_sup_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module wd_sup_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/wd_supervisor.sv
// Arms/disarms the watchdog, merges source liveness into a rate-limited
// heartbeat, forwards software trips and sequences recovery after a trip.
module wd_supervisor
    import wd_sup_pkg::*;
#(
    parameter int N_SRC          = DEFAULT_N_SRC,
    parameter int MIN_KICK_GAP   = DEFAULT_MIN_KICK_GAP,
    parameter int RECOVER_CYCLES = DEFAULT_RECOVER_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    disarm,
    input  logic [N_SRC-1:0]        src_alive,
    input  logic                    force_trip,
    input  logic                    wd_warning,
    input  logic                    wd_triggered,
    output logic                    wd_enable,
    output logic                    wd_heartbeat,
    output logic                    wd_force_reset,
    output logic                    sys_reset_req,
    output logic [N_SRC-1:0]        missing_mask,
    output logic [2:0]              state,
    output logic [TRIP_COUNT_W-1:0] trip_count
);

    localparam int GAP_W = $clog2(MIN_KICK_GAP + 1);
    localparam int TMR_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_KICK_GAP);
    localparam logic [GAP_W-1:0] GAP_KICK = GAP_W'(MIN_KICK_GAP - 1);

    wd_sup_state_t state_q, state_d;
    logic [N_SRC-1:0]        seen_q, seen_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    disarm_pend_q, disarm_pend_d;
    logic [TRIP_COUNT_W-1:0] trip_count_q, trip_count_d;
    logic                    force_prev_q;
    logic                    wd_enable_q, wd_enable_d;
    logic                    heartbeat_q, heartbeat_d;
    logic                    force_reset_q, force_reset_d;
    logic                    sys_reset_q, sys_reset_d;
    logic [N_SRC-1:0]        missing_q, missing_d;
    logic                    timer_load;
    logic                    timer_done;

    // Status only; deliberately has no effect on sequencing.
    logic unused_wd_warning;
    assign unused_wd_warning = wd_warning;

    wd_sup_timer #(
        .W(TMR_W)
    ) u_recover_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TMR_W'(RECOVER_CYCLES - 1)),
        .done     (timer_done)
    );

    always_comb begin
        state_d       = state_q;
        seen_d        = seen_q;
        gap_d         = gap_q;
        disarm_pend_d = disarm_pend_q;
        trip_count_d  = trip_count_q;
        timer_load    = 1'b0;

        unique case (state_q)
            ST_DISARMED: begin
                if (arm && !disarm) begin
                    state_d       = ST_ARMED;
                    seen_d        = '0;
                    gap_d         = '0;
                    disarm_pend_d = 1'b0;
                end
            end
            ST_ARMED: begin
                seen_d = seen_q | src_alive;
                if (gap_q < GAP_MAX) begin
                    gap_d = gap_q + GAP_W'(1);
                end
                if (disarm) begin
                    state_d = ST_DISARMED;
                end else if (wd_triggered) begin
                    state_d = ST_RECOVER;
                end else if ((&seen_q) && (gap_q >= GAP_KICK)) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                seen_d = src_alive;
                gap_d  = '0;
                if (disarm) begin
                    state_d = ST_DISARMED;
                end else if (wd_triggered) begin
                    state_d = ST_RECOVER;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_RECOVER: begin
                if (disarm) begin
                    disarm_pend_d = 1'b1;
                end
                if (timer_done) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (disarm) begin
                    disarm_pend_d = 1'b1;
                end
                if (!wd_triggered) begin
                    if (disarm_pend_d) begin
                        state_d = ST_DISARMED;
                    end else begin
                        state_d = ST_ARMED;
                        seen_d  = '0;
                        gap_d   = '0;
                    end
                end
            end
            default: state_d = ST_DISARMED;
        endcase

        if ((state_d == ST_RECOVER) && (state_q != ST_RECOVER)) begin
            timer_load = 1'b1;
            if (trip_count_q != '1) begin
                trip_count_d = trip_count_q + TRIP_COUNT_W'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        wd_enable_d   = is_supervising(state_d);
        heartbeat_d   = (state_d == ST_KICK);
        sys_reset_d   = (state_d == ST_RECOVER);
        missing_d     = is_supervising(state_d) ? ~seen_d : '0;
        force_reset_d = force_trip && !force_prev_q && is_supervising(state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_DISARMED;
            seen_q        <= '0;
            gap_q         <= '0;
            disarm_pend_q <= 1'b0;
            trip_count_q  <= '0;
            force_prev_q  <= 1'b0;
            wd_enable_q   <= 1'b0;
            heartbeat_q   <= 1'b0;
            force_reset_q <= 1'b0;
            sys_reset_q   <= 1'b0;
            missing_q     <= '0;
        end else begin
            state_q       <= state_d;
            seen_q        <= seen_d;
            gap_q         <= gap_d;
            disarm_pend_q <= disarm_pend_d;
            trip_count_q  <= trip_count_d;
            force_prev_q  <= force_trip;
            wd_enable_q   <= wd_enable_d;
            heartbeat_q   <= heartbeat_d;
            force_reset_q <= force_reset_d;
            sys_reset_q   <= sys_reset_d;
            missing_q     <= missing_d;
        end
    end

    assign state          = state_q;
    assign wd_enable      = wd_enable_q;
    assign wd_heartbeat   = heartbeat_q;
    assign wd_force_reset = force_reset_q;
    assign sys_reset_req  = sys_reset_q;
    assign missing_mask   = missing_q;
    assign trip_count     = trip_count_q;

endmodule

// File: doc/wd_supervisor.md
# wd_supervisor

Sequencing controller for `watchdog_timer` in the AM radio FPGA design. It arms and disarms the watchdog, and merges liveness pulses from several datapath blocks into one rate-limited heartbeat. It also issues a software trip on request and sequences system recovery after the watchdog fires. It sits between the per-block alive strobes and the single `watchdog_timer` instance, and drives the system reset request.

## Interface
Parameters:
- `N_SRC`, 4: number of liveness sources.
- `MIN_KICK_GAP`, 16: minimum number of cycles between heartbeats. Must be ≥2.
- `RECOVER_CYCLES`, 64: length of `sys_reset_req`. Must be ≥1.

Ports:
- `clk`  in  1  the single clock. All logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `arm`  in  1  level; request that supervision be enabled.
- `disarm`  in  1  level; request that supervision be disabled.
- `src_alive`  in  N_SRC  one strobe per source; a pulse of any width counts.
- `force_trip`  in  1  software request to trip the watchdog immediately.
- `wd_warning`  in  1  from `watchdog_timer`; status only.
- `wd_triggered`  in  1  from `watchdog_timer`.
- `wd_enable`  out  1  to the watchdog `enable` input.
- `wd_heartbeat`  out  1  to the watchdog `heartbeat` input; a one-cycle pulse.
- `wd_force_reset`  out  1  to the watchdog `force_reset` input; a one-cycle pulse.
- `sys_reset_req`  out  1  system reset request.
- `missing_mask`  out  N_SRC  sources not yet seen in the current window.
- `state`  out  3  current FSM state encoding.
- `trip_count`  out  8  number of watchdog trips; saturates at 255.

## Operation
The FSM has five states: DISARMED=0, ARMED=1, KICK=2, RECOVER=3, HOLDOFF=4.
- **DISARMED**
  - `wd_enable`=0.
  - `arm`=1 and `disarm`=0 → ARMED. Entry clears `seen`, clears `gap_cnt`, and clears the `disarm_pend` flag.
- **ARMED**
  - `wd_enable`=1.
  - Every cycle, `seen |= src_alive`.
  - `gap_cnt` increments each cycle and saturates at `MIN_KICK_GAP`.
  - Transition priority:
    1. `disarm` → DISARMED.
    2. `wd_triggered` → RECOVER.
    3. `seen` all ones and `gap_cnt`≥`MIN_KICK_GAP`-1 → KICK.
- **KICK**
  - Lasts exactly one cycle, with `wd_heartbeat`=1 and `wd_enable`=1.
  - `seen` is loaded with this cycle's `src_alive`, so a strobe in this cycle is not lost.
  - `gap_cnt` is set to 0.
  - Next state is ARMED. A `disarm` in this cycle → DISARMED; a `wd_triggered` in this cycle → RECOVER.
- **RECOVER**
  - `wd_enable`=0 and `sys_reset_req`=1 for exactly `RECOVER_CYCLES` cycles.
  - `trip_count` increments once, on entry.
  - Then → HOLDOFF.
- **HOLDOFF**
  - `wd_enable`=0.
  - Waits until `wd_triggered`=0 is sampled.
  - Then → DISARMED if `disarm_pend` is set, else → ARMED (with `seen` and `gap_cnt` cleared).

Other rules:
- `disarm` asserted during RECOVER or HOLDOFF sets `disarm_pend`.
- `force_trip`:
  - Honoured only in ARMED or KICK.
  - Produces exactly one `wd_force_reset` pulse per rising edge of `force_trip`.
  - Ignored in all other states.
- `missing_mask` equals `~seen` in ARMED and KICK, and is 0 in all other states.
- `wd_warning` does not affect the FSM.

## Timing
- All outputs are registered.
- Reset values:
  - `state` = DISARMED.
  - `wd_enable`, `wd_heartbeat`, `wd_force_reset`, `sys_reset_req` = 0.
  - `missing_mask` = 0.
  - `trip_count` = 0.
- Latencies:
  - A `src_alive` strobe in cycle t is reflected in `missing_mask` in cycle t+1.
  - `wd_heartbeat` is high in the cycle after the KICK condition is true.
  - The first heartbeat after `arm` comes no earlier than `MIN_KICK_GAP` cycles after entering ARMED.
  - A `force_trip` edge in cycle t gives `wd_force_reset` high in cycle t+1.
  - `wd_triggered` sampled in cycle t gives `sys_reset_req` high from t+1 through t+`RECOVER_CYCLES`.
- `gap_cnt` and `trip_count` saturate and never wrap.
- Reset asserted in any state, including mid-RECOVER: all outputs go to their reset values immediately (asynchronously). After release, the block starts in DISARMED regardless of `arm`. `trip_count` is also cleared.
- `arm` and `disarm` high in the same cycle: `disarm` wins.
- Sources stop: heartbeats stop. The resulting watchdog trip is the intended response.

## Structure
- Package `wd_sup_pkg` holds:
  - the state enum `wd_sup_state_t` with the encodings above;
  - default parameter constants;
  - the `TRIP_COUNT_W`=8 constant.
- Sub-module `wd_sup_timer`: a loadable down-counter with a `done` flag, used for the RECOVER duration.
- All other logic lives in the top FSM.

## Test plan
All scenarios use `N_SRC`=4, `MIN_KICK_GAP`=16, `RECOVER_CYCLES`=64.
- Normal kicking:
  - Stimulus: `arm`=1; all 4 sources pulse every 5 cycles.
  - Required response: `wd_heartbeat` pulses are exactly 1 cycle wide and at least 16 cycles apart. The first one is no earlier than cycle 16 after ARMED. `trip_count` stays 0.
- One source silent:
  - Stimulus: source 2 never pulses.
  - Required response: `missing_mask`=4'b0100 and no heartbeat. The watchdog trips; `sys_reset_req` is high for exactly 64 cycles; `trip_count`=1; the block re-enters ARMED after `wd_triggered` drops.
- Software trip:
  - Stimulus: `force_trip` held high for 10 cycles while ARMED.
  - Required response: exactly one `wd_force_reset` pulse. The same stimulus while DISARMED gives no pulse.
- Disarm during recovery:
  - Stimulus: pulse `disarm` in RECOVER cycle 10.
  - Required response: `sys_reset_req` still lasts 64 cycles, then the block ends in DISARMED with `wd_enable`=0.
- Reset mid-RECOVER:
  - Stimulus: assert `rst` asynchronously at RECOVER cycle 30.
  - Required response: `sys_reset_req`=0 and `state`=0 before the next clock edge, and `trip_count`=0.
- Simultaneous events:
  - Stimulus: `arm` and `disarm` both high.
  - Required response: the block stays DISARMED.
  - Stimulus: `wd_triggered` and the KICK condition in the same cycle.
  - Required response: the block goes to RECOVER and no heartbeat is issued.
